// File: rtl/bilinear_dest_scan.sv
// Scale-factor divider plus destination raster scanner: 20-cycle restoring divide, then one coordinate per valid/ready beat.
// Coordinates and markers hold while ready is low; DEST_SCAN_ROUND_EN selects round-to-nearest instead of truncation.
module bilinear_dest_scan #(
    parameter int INDEX_WIDTH = 11,
    parameter int INT_WIDTH   = 8,
    parameter int FIX_WIDTH   = 12
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           start_i,
    input  logic [INDEX_WIDTH-1:0]         srcx_width_i,
    input  logic [INDEX_WIDTH-1:0]         srcy_height_i,
    input  logic [INDEX_WIDTH-1:0]         destx_width_i,
    input  logic [INDEX_WIDTH-1:0]         desty_height_i,
    output logic [INT_WIDTH+FIX_WIDTH-1:0] scale_factorx_o,
    output logic [INT_WIDTH+FIX_WIDTH-1:0] scale_factory_o,
    output logic [INDEX_WIDTH-1:0]         destx_o,
    output logic [INDEX_WIDTH-1:0]         desty_o,
    output logic                           coord_valid_o,
    input  logic                           coord_ready_i,
    output logic                           sof_o,
    output logic                           eol_o,
    output logic                           eof_o,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           cfg_err_o
);

    localparam int SW  = INT_WIDTH + FIX_WIDTH;
    localparam int DVW = SW + INDEX_WIDTH;
    localparam int CW  = $clog2(SW);
    localparam logic [CW-1:0]          DIV_LAST = CW'(SW - 1);
    localparam logic [INDEX_WIDTH-1:0] ONE      = INDEX_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [INDEX_WIDTH-1:0] dst_w, dst_h;
    logic [CW-1:0]          div_cnt;
    logic [INDEX_WIDTH-1:0] rem_x, rem_y;
    logic [SW-1:0]          dvd_x, dvd_y;
    logic [SW-1:0]          quot_x, quot_y;
    logic                   ovf_x, ovf_y;
    logic                   cfg_err;

    // Full-width dividends for the incoming frame request
    logic [DVW-1:0]         dvd_x_full, dvd_y_full;
    logic [INDEX_WIDTH-1:0] hi_x, hi_y;
    logic                   size_bad;
    logic                   start_ok;

    always_comb begin
`ifdef DEST_SCAN_ROUND_EN
        dvd_x_full = (DVW'(srcx_width_i) << FIX_WIDTH) + DVW'(destx_width_i >> 1);
        dvd_y_full = (DVW'(srcy_height_i) << FIX_WIDTH) + DVW'(desty_height_i >> 1);
`else
        dvd_x_full = DVW'(srcx_width_i) << FIX_WIDTH;
        dvd_y_full = DVW'(srcy_height_i) << FIX_WIDTH;
`endif
        hi_x = dvd_x_full[DVW-1:SW];
        hi_y = dvd_y_full[DVW-1:SW];
    end

    assign size_bad = (destx_width_i == '0) || (desty_height_i == '0);
    assign start_ok = (state == IDLE) && start_i && !size_bad;

    // One restoring step per axis: shift in the next dividend bit, subtract if it fits
    logic [INDEX_WIDTH:0] trial_x, trial_y, diff_x, diff_y;
    logic                 ge_x, ge_y;

    always_comb begin
        trial_x = {rem_x, dvd_x[SW-1]};
        trial_y = {rem_y, dvd_y[SW-1]};
        ge_x    = trial_x >= {1'b0, dst_w};
        ge_y    = trial_y >= {1'b0, dst_h};
        diff_x  = trial_x - {1'b0, dst_w};
        diff_y  = trial_y - {1'b0, dst_h};
    end

    logic hs;
    logic at_eol, at_last_row;

    assign hs          = (state == SCAN) && coord_ready_i;
    assign at_eol      = destx_o == (dst_w - ONE);
    assign at_last_row = desty_o == (dst_h - ONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_ok) state_nxt = DIV;
            DIV:  if (div_cnt == DIV_LAST) state_nxt = SCAN;
            SCAN: if (hs && at_eol && at_last_row) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            dst_w   <= '0;
            dst_h   <= '0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= (state == IDLE) && start_i && size_bad;
            if ((state == IDLE) && start_i) begin
                dst_w <= destx_width_i;
                dst_h <= desty_height_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            div_cnt         <= '0;
            rem_x           <= '0;
            rem_y           <= '0;
            dvd_x           <= '0;
            dvd_y           <= '0;
            quot_x          <= '0;
            quot_y          <= '0;
            ovf_x           <= 1'b0;
            ovf_y           <= 1'b0;
            scale_factorx_o <= '0;
            scale_factory_o <= '0;
        end else if (start_ok) begin
            div_cnt <= '0;
            rem_x   <= hi_x;
            rem_y   <= hi_y;
            dvd_x   <= dvd_x_full[SW-1:0];
            dvd_y   <= dvd_y_full[SW-1:0];
            quot_x  <= '0;
            quot_y  <= '0;
            // Quotient cannot fit in SW bits when the top dividend slice already reaches the divisor
            ovf_x   <= hi_x >= destx_width_i;
            ovf_y   <= hi_y >= desty_height_i;
        end else if (state == DIV) begin
            div_cnt <= div_cnt + CW'(1);
            rem_x   <= ge_x ? diff_x[INDEX_WIDTH-1:0] : trial_x[INDEX_WIDTH-1:0];
            rem_y   <= ge_y ? diff_y[INDEX_WIDTH-1:0] : trial_y[INDEX_WIDTH-1:0];
            dvd_x   <= {dvd_x[SW-2:0], 1'b0};
            dvd_y   <= {dvd_y[SW-2:0], 1'b0};
            quot_x  <= {quot_x[SW-2:0], ge_x};
            quot_y  <= {quot_y[SW-2:0], ge_y};
            if (div_cnt == DIV_LAST) begin
                scale_factorx_o <= ovf_x ? '1 : {quot_x[SW-2:0], ge_x};
                scale_factory_o <= ovf_y ? '1 : {quot_y[SW-2:0], ge_y};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            destx_o <= '0;
            desty_o <= '0;
        end else if (start_ok) begin
            destx_o <= '0;
            desty_o <= '0;
        end else if (hs) begin
            if (at_eol) begin
                destx_o <= '0;
                desty_o <= at_last_row ? '0 : desty_o + ONE;
            end else begin
                destx_o <= destx_o + ONE;
            end
        end
    end

    assign coord_valid_o = (state == SCAN);
    assign sof_o         = coord_valid_o && (destx_o == '0) && (desty_o == '0);
    assign eol_o         = coord_valid_o && at_eol;
    assign eof_o         = coord_valid_o && at_eol && at_last_row;
    assign busy_o        = (state != IDLE);
    assign done_o        = (state == DONE);
    assign cfg_err_o     = cfg_err;

endmodule

// File: tb/tb_bilinear_dest_scan.sv
// Randomized frame bench for bilinear_dest_scan against a plain-arithmetic reference of scale and raster order.
module tb_bilinear_dest_scan;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic [10:0] srcx_width_i = '0, srcy_height_i = '0;
    logic [10:0] destx_width_i = '0, desty_height_i = '0;
    logic [19:0] scale_factorx_o, scale_factory_o;
    logic [10:0] destx_o, desty_o;
    logic        coord_valid_o;
    logic        coord_ready_i = 1'b0;
    logic        sof_o, eol_o, eof_o, busy_o, done_o, cfg_err_o;

    int n_chk = 0;
    int n_bad = 0;
    int exp_sx = 0;
    int exp_sy = 0;

    bilinear_dest_scan dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .srcx_width_i(srcx_width_i), .srcy_height_i(srcy_height_i),
        .destx_width_i(destx_width_i), .desty_height_i(desty_height_i),
        .scale_factorx_o(scale_factorx_o), .scale_factory_o(scale_factory_o),
        .destx_o(destx_o), .desty_o(desty_o),
        .coord_valid_o(coord_valid_o), .coord_ready_i(coord_ready_i),
        .sof_o(sof_o), .eol_o(eol_o), .eof_o(eof_o),
        .busy_o(busy_o), .done_o(done_o), .cfg_err_o(cfg_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int ref_scale(input int src, input int dst);
        longint dvd;
        longint q;
        dvd = longint'(src) * 4096;
`ifdef DEST_SCAN_ROUND_EN
        dvd = dvd + dst / 2;
`endif
        q = dvd / dst;
        if (q > 64'hFFFFF) q = 64'hFFFFF;
        return int'(q);
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_scale"}, {scale_factorx_o[15:0], scale_factory_o[15:0]}, 32'h0);
        chk({tag, "_scale_hi"}, {scale_factorx_o[19:16], scale_factory_o[19:16]}, 32'h0);
        chk({tag, "_coord"}, {destx_o, desty_o}, 32'h0);
        chk({tag, "_flags"}, {coord_valid_o, sof_o, eol_o, eof_o, busy_o, done_o, cfg_err_o}, 32'h0);
    endtask

    // abort_at >= 0 pulls reset while beat abort_at is presented
    task automatic run_frame(input int sw, input int sh, input int dw, input int dh,
                             input bit stalls, input bit noise, input int abort_at);
        int n, k, cyc, lat, stall, ex, ey;
        bit rdy, quiet;
        n = dw * dh;
        k = 0;
        cyc = 0;
        stall = 0;
        @(negedge clk_i);
        srcx_width_i   = 11'(sw);
        srcy_height_i  = 11'(sh);
        destx_width_i  = 11'(dw);
        desty_height_i = 11'(dh);
        start_i        = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        chk("busy_div", busy_o, 1);
        lat = 0;
        while (!coord_valid_o && lat < 40) begin
            @(posedge clk_i);
            #1 lat++;
        end
        chk("div_latency", lat, 20);
        exp_sx = ref_scale(sw, dw);
        exp_sy = ref_scale(sh, dh);
        chk("scale_x", scale_factorx_o, exp_sx);
        chk("scale_y", scale_factory_o, exp_sy);
        while (k < n && cyc < 4000) begin
            @(negedge clk_i);
            ex = k % dw;
            ey = k / dw;
            chk("valid", coord_valid_o, 1);
            chk("coord", {destx_o, desty_o}, {11'(ex), 11'(ey)});
            chk("markers", {sof_o, eol_o, eof_o}, {k == 0, ex == dw - 1, k == n - 1});
            chk("busy_scan", busy_o, 1);
            if (k == abort_at) begin
                rst_i = 1'b0;
                @(posedge clk_i);
                #1 check_all_zero("reset_mid");
                @(negedge clk_i);
                rst_i = 1'b1;
                coord_ready_i = 1'b0;
                exp_sx = 0;
                exp_sy = 0;
                quiet = 1'b1;
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk_i);
                    if (done_o || cfg_err_o || busy_o) quiet = 1'b0;
                end
                chk("after_abort_quiet", quiet, 1);
                return;
            end
            if (!stalls) begin
                rdy = 1'b1;
            end else if (stall > 0) begin
                rdy = 1'b0;
                stall--;
            end else if ($urandom_range(0, 2) == 0) begin
                rdy = 1'b0;
                stall = $urandom_range(0, 4);
            end else begin
                rdy = 1'b1;
            end
            coord_ready_i = rdy;
            if (noise && $urandom_range(0, 3) == 0) begin
                start_i = 1'b1;
                destx_width_i = 11'($urandom_range(0, 5));
                srcx_width_i  = 11'($urandom_range(0, 2047));
            end
            @(posedge clk_i);
            #1 start_i = 1'b0;
            if (rdy) k++;
            cyc++;
        end
        if (k < n) chk("scan_timeout", k, n);
        coord_ready_i = 1'b0;
        @(negedge clk_i);
        chk("done_pulse", {done_o, coord_valid_o, busy_o}, 3'b101);
        @(negedge clk_i);
        chk("done_end", {done_o, coord_valid_o, busy_o}, 3'b000);
        chk("scale_hold", {12'(scale_factorx_o), 20'(scale_factory_o)}, {12'(exp_sx), 20'(exp_sy)});
    endtask

    task automatic cfg_err_case(input int dw, input int dh);
        @(negedge clk_i);
        srcx_width_i   = 11'd100;
        srcy_height_i  = 11'd100;
        destx_width_i  = 11'(dw);
        desty_height_i = 11'(dh);
        start_i        = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        chk("cfg_err_pulse", {cfg_err_o, busy_o}, 2'b10);
        @(posedge clk_i);
        #1 chk("cfg_err_end", {cfg_err_o, busy_o, coord_valid_o}, 3'b000);
        chk("cfg_err_scale_x", scale_factorx_o, exp_sx);
        chk("cfg_err_scale_y", scale_factory_o, exp_sy);
    endtask

    initial begin
        rst_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 check_all_zero("reset");
        @(negedge clk_i);
        rst_i = 1'b1;

        run_frame(1920, 1080, 1280, 720, 1'b0, 1'b0, 0);
        run_frame(8, 8, 4, 2, 1'b0, 1'b0, -1);
        run_frame(3, 3, 7, 7, 1'b1, 1'b1, -1);
        run_frame(2, 2, 3, 3, 1'b1, 1'b0, -1);
        cfg_err_case(0, 5);
        cfg_err_case(5, 0);
        run_frame(2047, 2047, 1, 1, 1'b0, 1'b0, -1);
        cfg_err_case(0, 0);
        run_frame(10, 10, 4, 2, 1'b0, 1'b0, 6);
        run_frame(10, 10, 4, 2, 1'b1, 1'b1, -1);
        for (int f = 0; f < 8; f++) begin
            run_frame($urandom_range(1, 2047), $urandom_range(1, 2047),
                      $urandom_range(1, 6), $urandom_range(1, 4),
                      1'b1, 1'($urandom_range(0, 1)), -1);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
